bounded_rng: RTL and testbench

// Parametrised random-integer source for card dealing and shuffling. Captures an entropy seed by

---
 rtl/rng_pkg.sv | 47 ++++
 rtl/bounded_rng_if.sv | 21 ++
 rtl/xorshift_step.sv | 20 ++
 rtl/bounded_rng.sv | 155 +++++++++++++++
 tb/tb_bounded_rng.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// Shared types, shift constants and range-mask helper for the bounded random-integer source.
package rng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED,
    IDLE,
    GEN
  } fsm_e;

  localparam int SMEAR_W = 64;

  // Xorshift triples for the supported state widths; any other width falls back to the 16-bit set.
  function automatic int sh_a(input int width);
    case (width)
      32:      return 13;
      64:      return 13;
      default: return 7;
    endcase
  endfunction

  function automatic int sh_b(input int width);
    case (width)
      32:      return 17;
      64:      return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int sh_c(input int width);
    case (width)
      32:      return 5;
      64:      return 17;
      default: return 8;
    endcase
  endfunction

  // Sets every bit at or below the most significant set bit of v.
  function automatic logic [SMEAR_W-1:0] smear_mask(input logic [SMEAR_W-1:0] v);
    logic [SMEAR_W-1:0] m;
    m = v;
    for (int s = 1; s < SMEAR_W; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

endpackage

// File: rtl/bounded_rng_if.sv
// Request/result handshake between a game controller and the bounded random-integer source.
interface bounded_rng_if #(
  parameter int OUT_W = 6
);
  logic             req;
  logic [OUT_W-1:0] min_n;
  logic [OUT_W-1:0] max_n;
  logic             ready;
  logic             valid;
  logic [OUT_W-1:0] rand_int;

  modport master (
    output req, min_n, max_n,
    input  ready, valid, rand_int
  );

  modport slave (
    input  req, min_n, max_n,
    output ready, valid, rand_int
  );
endinterface

// File: rtl/xorshift_step.sv
// One combinational xorshift step; a non-zero input never maps to zero.
module xorshift_step
  import rng_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur_state,
  output logic [WIDTH-1:0] next_state
);
  localparam int A = sh_a(WIDTH);
  localparam int B = sh_b(WIDTH);
  localparam int C = sh_c(WIDTH);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  assign s1         = cur_state ^ (cur_state << A);
  assign s2         = s1 ^ (s1 >> B);
  assign next_state = s2 ^ (s2 << C);
endmodule

// File: rtl/bounded_rng.sv
// Seeded xorshift source returning uniform integers in [min_n, max_n) using mask-and-reject
// with a bounded number of attempts before a single-subtract fallback.
module bounded_rng
  import rng_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OUT_W   = 6,
  parameter int MAX_TRY = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         seed_en,
  bounded_rng_if.slave bus,
  output logic         seeded
);
  localparam int TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  fsm_e             fsm;
  fsm_e             fsm_nxt;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] seed_cnt;
  logic             seed_en_q;
  logic [OUT_W-1:0] lo;
  logic [OUT_W-1:0] hi;
  logic [TRY_W-1:0] try_cnt;
  logic             valid_q;
  logic [OUT_W-1:0] rand_q;

  logic             seed_rise;
  logic             seed_load;
  logic [OUT_W-1:0] range_w;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] cand;
  logic             degenerate;
  logic             hit;
  logic             last_try;

  logic             accept;
  logic             produce;
  logic             advance;
  logic             retry;
  logic [OUT_W-1:0] result;

  xorshift_step #(.WIDTH(WIDTH)) u_step (
    .cur_state  (state),
    .next_state (step)
  );

  assign seed_rise  = seed_en & ~seed_en_q;
  assign seed_load  = seed_en_q & ~seed_en;
  assign range_w    = hi - lo;
  assign degenerate = (hi <= lo);
  assign mask       = OUT_W'(smear_mask(SMEAR_W'(range_w - 1'b1)));
  assign cand       = step[OUT_W-1:0] & mask;
  assign hit        = (cand < range_w);
  assign last_try   = (try_cnt == TRY_W'(MAX_TRY - 1));

  assign bus.ready    = (fsm == IDLE);
  assign bus.valid    = valid_q;
  assign bus.rand_int = rand_q;

  // NOTE: every signal written here is given a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    fsm_nxt = fsm;
    accept  = 1'b0;
    produce = 1'b0;
    advance = 1'b0;
    retry   = 1'b0;
    result  = lo;
    unique case (fsm)
      UNSEEDED: ;
      IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          fsm_nxt = GEN;
        end
      end
      GEN: begin
        if (degenerate) begin
          produce = 1'b1;
          fsm_nxt = IDLE;
        end else begin
          advance = 1'b1;
          if (hit) begin
            produce = 1'b1;
            result  = lo + cand;
            fsm_nxt = IDLE;
          end else if (last_try) begin
            // cand < 2*range because the mask is below twice the range, so one subtract suffices.
            produce = 1'b1;
            result  = lo + (cand - range_w);
            fsm_nxt = IDLE;
          end else begin
            retry = 1'b1;
          end
        end
      end
      default: fsm_nxt = UNSEEDED;
    endcase
    // A seed load overrides whatever the FSM was doing, including an in-flight request.
    if (seed_load) begin
      fsm_nxt = IDLE;
      accept  = 1'b0;
      produce = 1'b0;
      advance = 1'b0;
      retry   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) fsm <= UNSEEDED;
    else       fsm <= fsm_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= WIDTH'(1);
      seed_cnt  <= '0;
      seed_en_q <= 1'b0;
      seeded    <= 1'b0;
      valid_q   <= 1'b0;
      rand_q    <= '0;
    end else begin
      seed_en_q <= seed_en;
      // The rising-edge cycle is itself the first counted cycle.
      if (seed_rise)    seed_cnt <= WIDTH'(1);
      else if (seed_en) seed_cnt <= seed_cnt + 1'b1;

      if (seed_load) begin
        state  <= (seed_cnt == '0) ? WIDTH'(1) : seed_cnt;
        seeded <= 1'b1;
      end else if (advance) begin
        state <= step;
      end

      valid_q <= produce;
      if (produce) rand_q <= result;
    end
  end

  // NOTE: latched bounds and the attempt counter are always written on accept before they are
  // read, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      lo      <= bus.min_n;
      hi      <= bus.max_n;
      try_cnt <= '0;
    end else if (retry) begin
      try_cnt <= try_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bounded_rng.sv
// Randomised scoreboard bench for bounded_rng against a plain-arithmetic reference model.
module tb_bounded_rng;
  localparam int WIDTH   = 16;
  localparam int OUT_W   = 6;
  localparam int MAX_TRY = 8;
  localparam int HIST_N  = 4000;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic seed_en;
  logic seeded;

  bounded_rng_if #(.OUT_W(OUT_W)) bus ();

  bounded_rng #(.WIDTH(WIDTH), .OUT_W(OUT_W), .MAX_TRY(MAX_TRY)) dut (
    .clock   (clock),
    .reset   (reset),
    .seed_en (seed_en),
    .bus     (bus),
    .seeded  (seeded)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  exp_t        sb[$];
  int unsigned m_state  = 1;
  bit          hist_en  = 1'b0;
  int          hist[64];
  logic        prev_valid = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one xorshift step on a 16-bit value.
  function automatic int unsigned xs(input int unsigned x);
    x = (x ^ (x << 7)) & 32'hFFFF;
    x = x ^ (x >> 9);
    x = (x ^ (x << 8)) & 32'hFFFF;
    return x;
  endfunction

  // Draws from the model the way the rules describe: smallest power of two covering the range,
  // retry while out of range, after the last attempt subtract the range once.
  function automatic void predict(input int mn, input int mx, inout int unsigned st,
                                  output int val, output int tries);
    int rng;
    int span;
    int c;
    val   = mn;
    tries = 1;
    if (mx <= mn) return;
    rng  = mx - mn;
    span = 1;
    while (span < rng) span = span * 2;
    for (int t = 1; t <= MAX_TRY; t++) begin
      st    = xs(st);
      c     = int'(st % span);
      tries = t;
      if (c < rng) begin
        val = mn + c;
        return;
      end
      if (t == MAX_TRY) val = mn + c - rng;
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.valid) begin
      check("valid_single_pulse", prev_valid, 0);
      check("valid_has_pending_request", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rand_int", bus.rand_int, e.val);
        check("latency_cycle", cyc, e.due);
        if (hist_en) begin
          hist[bus.rand_int]++;
          check("hist_in_range", bus.rand_int < 6'd52, 1);
        end
      end
    end
    prev_valid = reset ? 1'b0 : bus.valid;
  end

  task automatic do_req(input int mn, input int mx);
    int val;
    int k;
    int guard;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("ready_for_request", bus.ready, 1);
    if (!bus.ready) return;
    predict(mn, mx, m_state, val, k);
    bus.req   = 1'b1;
    bus.min_n = OUT_W'(mn);
    bus.max_n = OUT_W'(mx);
    sb.push_back('{val, cyc + 1 + k});
    @(posedge clock);
    #1;
    bus.req   = 1'b0;
    bus.min_n = OUT_W'($urandom);
    bus.max_n = OUT_W'($urandom);
    @(negedge clock);
    if (k > 1) check("ready_low_in_gen", bus.ready, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clock);
      #1;
      guard++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  task automatic do_seed(input int n);
    seed_en = 1'b1;
    repeat (n) @(negedge clock);
    seed_en = 1'b0;
    @(negedge clock);
    m_state = n % 65536;
    if (m_state == 0) m_state = 1;
    check("seeded_after_load", seeded, 1);
    check("ready_after_load", bus.ready, 1);
  endtask

  initial begin
    int          mn;
    int          mx;
    int unsigned st;
    int          c;
    bit          ok;
    bit          found;
    int          rej_seed;
    int          rej_exp;
    real         e_bin;
    real         d;
    real         chi;
    int          total;

    reset     = 1'b1;
    seed_en   = 1'b0;
    bus.req   = 1'b0;
    bus.min_n = '0;
    bus.max_n = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready", bus.ready, 0);
    check("reset_valid", bus.valid, 0);
    check("reset_rand_int", bus.rand_int, 0);
    check("reset_seeded", seeded, 0);

    // Requests before seeding are ignored.
    bus.req   = 1'b1;
    bus.min_n = 6'd0;
    bus.max_n = 6'd20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("unseeded_ready_low", bus.ready, 0);
    end
    bus.req = 1'b0;

    // Seed 5: degenerate request leaves the state alone, then the 0x8684 draw yields 5.
    do_seed(5);
    do_req(9, 9);
    drain();
    check("degenerate_result", bus.rand_int, 9);
    do_req(1, 53);
    drain();
    check("seed5_first_draw", bus.rand_int, 5);

    // Seed whose first eight candidates all miss range 33, forcing the fallback path.
    found    = 1'b0;
    rej_seed = 1;
    rej_exp  = 0;
    for (int s = 1; s < 65536 && !found; s++) begin
      st = s;
      ok = 1'b1;
      c  = 0;
      for (int t = 0; t < MAX_TRY; t++) begin
        st = xs(st);
        c  = int'(st & 63);
        if (c < 33) ok = 1'b0;
      end
      if (ok) begin
        found    = 1'b1;
        rej_seed = s;
        rej_exp  = 10 + c - 33;
      end
    end
    check("reject_seed_found", found, 1);
    do_seed(rej_seed);
    do_req(10, 43);
    drain();
    check("reject_fallback_value", bus.rand_int, rej_exp);
    check("reject_below_bound", bus.rand_int < 6'd43, 1);

    // Counter wraps to zero, which loads state 1.
    do_seed(65536);
    do_req(0, 52);
    drain();

    // Drop seed_en while a request is in GEN: the request is abandoned and the new seed takes over.
    seed_en = 1'b1;
    repeat (20) @(negedge clock);
    bus.req   = 1'b1;
    bus.min_n = 6'd0;
    bus.max_n = 6'd52;
    @(posedge clock);
    #1;
    bus.req = 1'b0;
    @(negedge clock);
    check("abort_in_gen", bus.ready, 0);
    seed_en = 1'b0;
    @(negedge clock);
    m_state = 21;
    check("abort_ready", bus.ready, 1);
    check("abort_seeded", seeded, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", bus.valid, 0);
      @(negedge clock);
    end
    do_req(3, 40);
    drain();

    // Random bounds, including empty and single-value ranges, with random idle gaps.
    for (int i = 0; i < 200; i++) begin
      mn = int'($urandom_range(0, 63));
      mx = int'($urandom_range(0, 63));
      if (i % 10 == 0) mx = (mn < 63) ? mn + 1 : mn;
      do_req(mn, mx);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    drain();

    // Back-to-back draws over a 52-card deck for a uniformity check.
    hist_en = 1'b1;
    for (int i = 0; i < HIST_N; i++) do_req(0, 52);
    drain();
    hist_en = 1'b0;

    e_bin = real'(HIST_N) / 52.0;
    chi   = 0.0;
    total = 0;
    for (int i = 0; i < 64; i++) begin
      total += hist[i];
      if (i < 52) begin
        d   = real'(hist[i]) - e_bin;
        chi = chi + d * d / e_bin;
      end
    end
    check("hist_total", total, HIST_N);
    check("chi_square_below_100", chi < 100.0, 1);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
